// File: rtl/pipe_trace_checker.sv
// Lockstep commit checker: buffers the DUT and reference write-back streams, compares them in
// program order and keeps a circular trace of compared DUT commits for post-mortem debug.
module pipe_trace_checker #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned QDEPTH  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENABLE,
    input  logic                     FREEZE_ON_ERR,
    input  logic                     DUT_WB_VALID,
    input  logic [XLEN-1:0]          DUT_WB_PC,
    input  logic [4:0]               DUT_WB_RD,
    input  logic [XLEN-1:0]          DUT_WB_DATA,
    input  logic                     REF_WB_VALID,
    input  logic [XLEN-1:0]          REF_WB_PC,
    input  logic [4:0]               REF_WB_RD,
    input  logic [XLEN-1:0]          REF_WB_DATA,
    input  logic [$clog2(DEPTH)-1:0] RD_IDX,
    output logic [XLEN-1:0]          RD_PC,
    output logic [4:0]               RD_RD,
    output logic [XLEN-1:0]          RD_DATA,
    output logic [$clog2(DEPTH):0]   TB_COUNT,
    output logic [1:0]               STATE,
    output logic                     ERR,
    output logic [2:0]               ERR_CODE,
    output logic [XLEN-1:0]          ERR_PC,
    output logic [31:0]              CYCLE_CNT,
    output logic [31:0]              COMMIT_CNT
);
    localparam int unsigned TW = $clog2(DEPTH);
    localparam int unsigned QW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [QW:0] QFull   = (QW + 1)'(QDEPTH);
    localparam logic [TW:0] TbFull  = (TW + 1)'(DEPTH);
    localparam logic [CW-1:0] ToLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StError = 2'd2} state_e;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    state_e          state_q, state_d;
    entry_t          dq_mem [QDEPTH];
    entry_t          rq_mem [QDEPTH];
    entry_t          tb_mem [DEPTH];
    logic [QW-1:0]   dq_wptr_q, dq_wptr_d, dq_rptr_q, dq_rptr_d;
    logic [QW-1:0]   rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
    logic [QW:0]     dq_cnt_q, dq_cnt_d, rq_cnt_q, rq_cnt_d;
    logic [CW-1:0]   to_q, to_d;
    logic [TW-1:0]   tb_wptr_q, tb_wptr_d;
    logic [TW:0]     tb_cnt_q, tb_cnt_d;
    logic            err_q, err_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [XLEN-1:0] err_pc_q, err_pc_d;
    logic [31:0]     cyc_q, cyc_d, commit_q, commit_d;

    entry_t          dut_in, ref_in, dq_head, rq_head, rd_entry;
    logic            active, cmp, d_push, r_push, d_ovf, r_ovf, one_sided, to_err, tb_we;
    logic [2:0]      new_code;
    logic [XLEN-1:0] new_pc;
    logic [TW-1:0]   rd_ptr;

    assign dut_in    = '{pc: DUT_WB_PC, rd: DUT_WB_RD, data: DUT_WB_DATA};
    assign ref_in    = '{pc: REF_WB_PC, rd: REF_WB_RD, data: REF_WB_DATA};
    assign dq_head   = dq_mem[dq_rptr_q];
    assign rq_head   = rq_mem[rq_rptr_q];
    assign active    = (state_q == StRun) && ENABLE;
    assign cmp       = active && (dq_cnt_q != '0) && (rq_cnt_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
    assign d_push    = active && DUT_WB_VALID && ((dq_cnt_q != QFull) || cmp);
    assign r_push    = active && REF_WB_VALID && ((rq_cnt_q != QFull) || cmp);
    assign d_ovf     = active && DUT_WB_VALID && (dq_cnt_q == QFull) && !cmp;
    assign r_ovf     = active && REF_WB_VALID && (rq_cnt_q == QFull) && !cmp;
    assign one_sided = active && ((dq_cnt_q != '0) != (rq_cnt_q != '0));
    assign to_err    = one_sided && (to_q == ToLast);
    assign tb_we     = cmp && !((state_q == StError) && FREEZE_ON_ERR);

    always_comb begin
        new_code = 3'd0;
        new_pc   = dq_head.pc;
        if (d_ovf) begin
            new_code = 3'd5;
            new_pc   = DUT_WB_PC;
        end else if (r_ovf) begin
            new_code = 3'd6;
            new_pc   = REF_WB_PC;
        end else if (to_err) begin
            new_code = 3'd4;
            new_pc   = (dq_cnt_q != '0) ? dq_head.pc : rq_head.pc;
        end else if (cmp && (dq_head.pc != rq_head.pc)) begin
            new_code = 3'd1;
        end else if (cmp && (dq_head.rd != rq_head.rd)) begin
            new_code = 3'd2;
        end else if (cmp && (dq_head.rd != 5'd0) && (dq_head.data != rq_head.data)) begin
            new_code = 3'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        dq_wptr_d  = '0;
        dq_rptr_d  = '0;
        dq_cnt_d   = '0;
        rq_wptr_d  = '0;
        rq_rptr_d  = '0;
        rq_cnt_d   = '0;
        to_d       = '0;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        cyc_d      = cyc_q;
        commit_d   = commit_q;
        tb_wptr_d  = tb_wptr_q;
        tb_cnt_d   = tb_cnt_q;

        // Queues are only live while actively checking; otherwise they collapse to empty.
        if (active) begin
            dq_wptr_d = d_push ? dq_wptr_q + 1'b1 : dq_wptr_q;
            rq_wptr_d = r_push ? rq_wptr_q + 1'b1 : rq_wptr_q;
            dq_rptr_d = cmp ? dq_rptr_q + 1'b1 : dq_rptr_q;
            rq_rptr_d = cmp ? rq_rptr_q + 1'b1 : rq_rptr_q;
            case ({d_push, cmp})
                2'b10:   dq_cnt_d = dq_cnt_q + 1'b1;
                2'b01:   dq_cnt_d = dq_cnt_q - 1'b1;
                default: dq_cnt_d = dq_cnt_q;
            endcase
            case ({r_push, cmp})
                2'b10:   rq_cnt_d = rq_cnt_q + 1'b1;
                2'b01:   rq_cnt_d = rq_cnt_q - 1'b1;
                default: rq_cnt_d = rq_cnt_q;
            endcase
            to_d = one_sided ? to_q + 1'b1 : '0;
        end

        if (state_q == StRun && cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (cmp && commit_q != '1) commit_d = commit_q + 1'b1;
        if (tb_we) begin
            tb_wptr_d = tb_wptr_q + 1'b1;
            if (tb_cnt_q != TbFull) tb_cnt_d = tb_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: if (ENABLE) state_d = StRun;
            StRun: begin
                if (!ENABLE) begin
                    state_d = StIdle;
                end else if (new_code != 3'd0) begin
                    state_d    = StError;
                    err_d      = 1'b1;
                    err_code_d = new_code;
                    err_pc_d   = new_pc;
                end
            end
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            dq_wptr_q  <= '0;
            dq_rptr_q  <= '0;
            dq_cnt_q   <= '0;
            rq_wptr_q  <= '0;
            rq_rptr_q  <= '0;
            rq_cnt_q   <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            err_pc_q   <= '0;
            cyc_q      <= '0;
            commit_q   <= '0;
            tb_wptr_q  <= '0;
            tb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            dq_wptr_q  <= dq_wptr_d;
            dq_rptr_q  <= dq_rptr_d;
            dq_cnt_q   <= dq_cnt_d;
            rq_wptr_q  <= rq_wptr_d;
            rq_rptr_q  <= rq_rptr_d;
            rq_cnt_q   <= rq_cnt_d;
            to_q       <= to_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            cyc_q      <= cyc_d;
            commit_q   <= commit_d;
            tb_wptr_q  <= tb_wptr_d;
            tb_cnt_q   <= tb_cnt_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters decide what is valid.
    always_ff @(posedge CLK) begin
        if (d_push) dq_mem[dq_wptr_q] <= dut_in;
        if (r_push) rq_mem[rq_wptr_q] <= ref_in;
        if (tb_we)  tb_mem[tb_wptr_q] <= dq_head;
    end

    assign rd_ptr   = tb_wptr_q - 1'b1 - RD_IDX;
    assign rd_entry = ({1'b0, RD_IDX} < tb_cnt_q) ? tb_mem[rd_ptr] : '0;

    assign RD_PC      = rd_entry.pc;
    assign RD_RD      = rd_entry.rd;
    assign RD_DATA    = rd_entry.data;
    assign TB_COUNT   = tb_cnt_q;
    assign STATE      = state_q;
    assign ERR        = err_q;
    assign ERR_CODE   = err_code_q;
    assign ERR_PC     = err_pc_q;
    assign CYCLE_CNT  = cyc_q;
    assign COMMIT_CNT = commit_q;
endmodule

// File: tb/tb_pipe_trace_checker.sv
// Bench for pipe_trace_checker: directed scenarios plus random commit streams, all checked
// every cycle against a queue-based reference model.
module tb_pipe_trace_checker;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned QDEPTH  = 8;
    localparam int unsigned TIMEOUT = 64;
    localparam int NPROG = 512;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        FREEZE_ON_ERR = 1'b0;
    logic        DUT_WB_VALID = 1'b0;
    logic [31:0] DUT_WB_PC = '0;
    logic [4:0]  DUT_WB_RD = '0;
    logic [31:0] DUT_WB_DATA = '0;
    logic        REF_WB_VALID = 1'b0;
    logic [31:0] REF_WB_PC = '0;
    logic [4:0]  REF_WB_RD = '0;
    logic [31:0] REF_WB_DATA = '0;
    logic [3:0]  RD_IDX = '0;
    logic [31:0] RD_PC, RD_DATA, ERR_PC, CYCLE_CNT, COMMIT_CNT;
    logic [4:0]  RD_RD, TB_COUNT;
    logic [1:0]  STATE;
    logic        ERR;
    logic [2:0]  ERR_CODE;

    pipe_trace_checker #(
        .XLEN(XLEN), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FREEZE_ON_ERR(FREEZE_ON_ERR),
        .DUT_WB_VALID(DUT_WB_VALID), .DUT_WB_PC(DUT_WB_PC), .DUT_WB_RD(DUT_WB_RD),
        .DUT_WB_DATA(DUT_WB_DATA),
        .REF_WB_VALID(REF_WB_VALID), .REF_WB_PC(REF_WB_PC), .REF_WB_RD(REF_WB_RD),
        .REF_WB_DATA(REF_WB_DATA),
        .RD_IDX(RD_IDX), .RD_PC(RD_PC), .RD_RD(RD_RD), .RD_DATA(RD_DATA),
        .TB_COUNT(TB_COUNT), .STATE(STATE), .ERR(ERR), .ERR_CODE(ERR_CODE), .ERR_PC(ERR_PC),
        .CYCLE_CNT(CYCLE_CNT), .COMMIT_CNT(COMMIT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    int          m_st;
    ent_t        m_dq[$];
    ent_t        m_rq[$];
    ent_t        m_tr[$];
    int          m_to;
    bit          m_err;
    int          m_code;
    logic [31:0] m_epc;
    longint      m_cyc, m_commit;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_dq.delete(); m_rq.delete(); m_tr.delete();
        m_to = 0; m_err = 0; m_code = 0; m_epc = '0; m_cyc = 0; m_commit = 0;
    endtask

    task automatic model_update();
        bit   cmp, one, dovf, rovf;
        int   code;
        logic [31:0] epc;
        ent_t din, rin;
        if (RST) begin
            model_reset();
            return;
        end
        if (m_st == 0) begin
            if (ENABLE) m_st = 1;
        end else if (m_st == 1) begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (!ENABLE) begin
                m_st = 0; m_dq.delete(); m_rq.delete(); m_to = 0;
            end else begin
                din  = '{pc: DUT_WB_PC, rd: DUT_WB_RD, data: DUT_WB_DATA};
                rin  = '{pc: REF_WB_PC, rd: REF_WB_RD, data: REF_WB_DATA};
                cmp  = (m_dq.size() > 0) && (m_rq.size() > 0);
                one  = (m_dq.size() > 0) != (m_rq.size() > 0);
                dovf = DUT_WB_VALID && (m_dq.size() == QDEPTH) && !cmp;
                rovf = REF_WB_VALID && (m_rq.size() == QDEPTH) && !cmp;
                code = 0;
                epc  = 0;
                if (dovf) begin code = 5; epc = din.pc; end
                else if (rovf) begin code = 6; epc = rin.pc; end
                else if (one && m_to == TIMEOUT - 1) begin
                    code = 4;
                    epc  = (m_dq.size() > 0) ? m_dq[0].pc : m_rq[0].pc;
                end else if (cmp) begin
                    epc = m_dq[0].pc;
                    if (m_dq[0].pc != m_rq[0].pc) code = 1;
                    else if (m_dq[0].rd != m_rq[0].rd) code = 2;
                    else if (m_dq[0].rd != 0 && m_dq[0].data != m_rq[0].data) code = 3;
                end
                if (cmp) begin
                    m_tr.push_front(m_dq[0]);
                    if (m_tr.size() > DEPTH) void'(m_tr.pop_back());
                    void'(m_dq.pop_front());
                    void'(m_rq.pop_front());
                    if (m_commit < 64'hFFFF_FFFF) m_commit++;
                end
                if (DUT_WB_VALID && !dovf) m_dq.push_back(din);
                if (REF_WB_VALID && !rovf) m_rq.push_back(rin);
                m_to = one ? m_to + 1 : 0;
                if (code != 0) begin
                    m_st = 2; m_err = 1; m_code = code; m_epc = epc;
                end
            end
        end
    endtask

    task automatic check_all();
        ent_t e;
        e = (RD_IDX < m_tr.size()) ? m_tr[RD_IDX] : '0;
        check_eq("state", STATE, m_st);
        check_eq("err", ERR, m_err);
        check_eq("err_code", ERR_CODE, m_code);
        check_eq("err_pc", ERR_PC, m_epc);
        check_eq("cycle_cnt", CYCLE_CNT, m_cyc);
        check_eq("commit_cnt", COMMIT_CNT, m_commit);
        check_eq("tb_count", TB_COUNT, m_tr.size());
        check_eq("rd_pc", RD_PC, e.pc);
        check_eq("rd_rd", RD_RD, e.rd);
        check_eq("rd_data", RD_DATA, e.data);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(input bit dv, input logic [31:0] dpc, input logic [4:0] drd,
                         input logic [31:0] dd, input bit rv, input logic [31:0] rpc,
                         input logic [4:0] rrd, input logic [31:0] rd);
        DUT_WB_VALID = dv; DUT_WB_PC = dpc; DUT_WB_RD = drd; DUT_WB_DATA = dd;
        REF_WB_VALID = rv; REF_WB_PC = rpc; REF_WB_RD = rrd; REF_WB_DATA = rd;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RST = 1; ENABLE = 0;
        idle(2);
        RST = 0;
    endtask

    task automatic start_run();
        ENABLE = 1;
        idle(1);
    endtask

    logic [31:0] prog_pc[NPROG];
    logic [4:0]  prog_rd[NPROG];
    logic [31:0] prog_dat[NPROG];

    initial begin
        int n;
        logic [31:0] d;
        model_reset();
        do_reset();
        check_eq("rst_state", STATE, 0);
        check_eq("rst_err", ERR, 0);
        check_eq("rst_tb_count", TB_COUNT, 0);

        // Lockstep match of 16 pairs
        start_run();
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            drive(1, k * 4, 5'(k + 1), d, 1, k * 4, 5'(k + 1), d);
            step();
        end
        idle(3);
        check_eq("lock_err", ERR, 0);
        check_eq("lock_commit", COMMIT_CNT, 16);
        check_eq("lock_tbcnt", TB_COUNT, 16);
        RD_IDX = 0; #1;
        check_eq("lock_idx0_pc", RD_PC, 60);
        RD_IDX = 15; #1;
        check_eq("lock_idx15_pc", RD_PC, 0);
        RD_IDX = 0;

        // Skewed rates
        do_reset();
        start_run();
        for (int c = 0; c < 20; c++) begin
            drive(c < 5, (c % 5) * 4, 5'd3, 32'h100 + (c % 5), 0, 0, 0, 0);
            if (c % 4 == 0) begin
                REF_WB_VALID = 1; REF_WB_PC = (c / 4) * 4; REF_WB_RD = 5'd3;
                REF_WB_DATA = 32'h100 + (c / 4);
            end
            step();
        end
        idle(3);
        check_eq("skew_err", ERR, 0);
        check_eq("skew_commit", COMMIT_CNT, 5);

        // Data mismatch on the third pair
        do_reset();
        start_run();
        for (int k = 0; k < 6; k++) begin
            drive(1, k * 4, 5'd5, (k == 2) ? 32'h10 : 32'h7, 1, k * 4, 5'd5,
                  (k == 2) ? 32'h11 : 32'h7);
            step();
        end
        idle(3);
        check_eq("dmis_err", ERR, 1);
        check_eq("dmis_code", ERR_CODE, 3);
        check_eq("dmis_pc", ERR_PC, 8);
        check_eq("dmis_state", STATE, 2);
        check_eq("dmis_commit", COMMIT_CNT, 3);

        // x0 data is don't-care
        do_reset();
        start_run();
        drive(1, 32'h40, 5'd0, 32'hAA, 1, 32'h40, 5'd0, 32'h55);
        step();
        idle(3);
        check_eq("x0_err", ERR, 0);
        check_eq("x0_commit", COMMIT_CNT, 1);

        // Timeout: one DUT commit, REF silent
        do_reset();
        start_run();
        drive(1, 32'h200, 5'd1, 32'h1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (!ERR && n < 4 * TIMEOUT) begin
            step();
            n++;
        end
        check_eq("to_latency", n, TIMEOUT);
        check_eq("to_code", ERR_CODE, 4);
        check_eq("to_pc", ERR_PC, 32'h200);

        // Overflow: 9 DUT commits, REF silent
        do_reset();
        start_run();
        for (int k = 0; k < 9; k++) begin
            drive(1, 32'h100 + k * 4, 5'd2, k, 0, 0, 0, 0);
            step();
        end
        idle(2);
        check_eq("ovf_code", ERR_CODE, 5);
        check_eq("ovf_pc", ERR_PC, 32'h120);

        // Wrap and freeze
        do_reset();
        FREEZE_ON_ERR = 1;
        start_run();
        for (int k = 0; k < 20; k++) begin
            d = $urandom;
            drive(1, k * 4, 5'(k), d, 1, k * 4, 5'(k), d);
            step();
        end
        drive(1, 80, 5'd1, 0, 1, 84, 5'd1, 0);
        step();
        idle(3);
        check_eq("wrap_code", ERR_CODE, 1);
        check_eq("wrap_tbcnt", TB_COUNT, 16);
        RD_IDX = 0; #1;
        check_eq("wrap_idx0_pc", RD_PC, 80);
        RD_IDX = 15; #1;
        check_eq("wrap_idx15_pc", RD_PC, 20);
        RD_IDX = 0;
        RST = 1;
        step();
        check_eq("rst2_state", STATE, 0);
        check_eq("rst2_err", ERR, 0);
        check_eq("rst2_code", ERR_CODE, 0);
        check_eq("rst2_pc", ERR_PC, 0);
        check_eq("rst2_cyc", CYCLE_CNT, 0);
        check_eq("rst2_commit", COMMIT_CNT, 0);
        check_eq("rst2_tbcnt", TB_COUNT, 0);
        check_eq("rst2_rdpc", RD_PC, 0);
        RST = 0;

        // Random streams against the model
        for (int ep = 0; ep < 8; ep++) begin
            int di, ri;
            bit dv, rv;
            do_reset();
            FREEZE_ON_ERR = 1'($urandom_range(0, 1));
            for (int k = 0; k < NPROG; k++) begin
                prog_pc[k]  = (ep << 12) + k * 4;
                prog_rd[k]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                prog_dat[k] = $urandom;
            end
            di = 0; ri = 0;
            ENABLE = 1;
            for (int c = 0; c < 350; c++) begin
                dv = ($urandom_range(0, 99) < 50) && di < NPROG;
                rv = ($urandom_range(0, 99) < 50) && ri < NPROG;
                if (di - ri > 5 && $urandom_range(0, 49) != 0) dv = 0;
                if (ri - di > 5 && $urandom_range(0, 49) != 0) rv = 0;
                drive(dv, dv ? prog_pc[di] : 0, dv ? prog_rd[di] : 0, dv ? prog_dat[di] : 0,
                      rv, rv ? prog_pc[ri] : 0, rv ? prog_rd[ri] : 0, rv ? prog_dat[ri] : 0);
                if (rv && $urandom_range(0, 299) == 0) begin
                    case ($urandom_range(0, 2))
                        0: REF_WB_PC = REF_WB_PC ^ 32'h4;
                        1: REF_WB_RD = REF_WB_RD ^ 5'h1;
                        default: REF_WB_DATA = REF_WB_DATA ^ 32'h1;
                    endcase
                end
                if (dv) di++;
                if (rv) ri++;
                ENABLE = ($urandom_range(0, 149) != 0);
                RD_IDX = 4'($urandom_range(0, DEPTH - 1));
                step();
                // Leaving RUN flushes both queues, so the streams restart in step.
                if (m_st == 0) ri = di;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
